// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants and the common-data-bus packet format.
package tomasulo_pkg;

  localparam int DATA_W        = 16;
  localparam int ROB_W         = 3;
  localparam int REG_W         = 4;
  localparam int RS_W          = 3;
  localparam int DEF_BUF_DEPTH = 2;

  localparam logic SRC_ADD = 1'b0;
  localparam logic SRC_MUL = 1'b1;

  typedef struct packed {
    logic              src;
    logic [ROB_W-1:0]  rob_ind;
    logic [REG_W-1:0]  rd;
    logic [RS_W-1:0]   rs_index;
    logic [DATA_W-1:0] data;
  } cdb_pkt;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding completed results of one execution unit.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk1,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk1) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk1) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/cdb_writeback_arb.sv
// CDB writeback stage: buffers add and mul/div results, round-robin picks one per cycle
// and broadcasts it from registered cdb_* outputs.
module cdb_writeback_arb
  import tomasulo_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                       clk1,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       add_valid,
  output logic                       add_ready,
  input  logic [ROB_W-1:0]           add_rob_ind,
  input  logic [REG_W-1:0]           add_rd,
  input  logic [RS_W-1:0]            add_rs_index,
  input  logic [DATA_W-1:0]          add_data,
  input  logic                       mul_valid,
  output logic                       mul_ready,
  input  logic [ROB_W-1:0]           mul_rob_ind,
  input  logic [REG_W-1:0]           mul_rd,
  input  logic [RS_W-1:0]            mul_rs_index,
  input  logic [DATA_W-1:0]          mul_data,
  output logic                       cdb_valid,
  output logic                       cdb_src,
  output logic [ROB_W-1:0]           cdb_rob_ind,
  output logic [REG_W-1:0]           cdb_rd,
  output logic [RS_W-1:0]            cdb_rs_index,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       dbg_rr_last,
  output logic [$clog2(BUF_DEPTH):0] dbg_add_count,
  output logic [$clog2(BUF_DEPTH):0] dbg_mul_count
);

  localparam int PKT_W = $bits(cdb_pkt);

  cdb_pkt add_in, mul_in, add_head, mul_head, win;
  logic   add_full, mul_full, add_empty, mul_empty;
  logic   grant_add, grant_mul;
  logic   rr_last;

  // Handshake: a result transfers on a posedge where valid && ready. Producers hold valid and
  // payload until accepted; ready reflects buffer space only, never the same-cycle pop.
  assign add_ready = !add_full && !reset && !flush;
  assign mul_ready = !mul_full && !reset && !flush;

  always_comb begin
    add_in = '{src: SRC_ADD, rob_ind: add_rob_ind, rd: add_rd, rs_index: add_rs_index, data: add_data};
    mul_in = '{src: SRC_MUL, rob_ind: mul_rob_ind, rd: mul_rd, rs_index: mul_rs_index, data: mul_data};
  end

  result_fifo #(.WIDTH(PKT_W), .DEPTH(BUF_DEPTH)) u_add_fifo (
    .clk1(clk1), .reset(reset), .flush(flush),
    .push(add_valid && add_ready), .pop(grant_add), .din(add_in), .dout(add_head),
    .full(add_full), .empty(add_empty), .count(dbg_add_count)
  );

  result_fifo #(.WIDTH(PKT_W), .DEPTH(BUF_DEPTH)) u_mul_fifo (
    .clk1(clk1), .reset(reset), .flush(flush),
    .push(mul_valid && mul_ready), .pop(grant_mul), .din(mul_in), .dout(mul_head),
    .full(mul_full), .empty(mul_empty), .count(dbg_mul_count)
  );

  // On contention the source that lost last time wins; rr_last records the last grant.
  always_comb begin
    grant_add = 1'b0;
    grant_mul = 1'b0;
    if (!reset && !flush) begin
      if (!add_empty && !mul_empty) begin
        if (rr_last == SRC_ADD) grant_mul = 1'b1;
        else                    grant_add = 1'b1;
      end else if (!add_empty) begin
        grant_add = 1'b1;
      end else if (!mul_empty) begin
        grant_mul = 1'b1;
      end
    end
  end

  assign win         = grant_mul ? mul_head : add_head;
  assign dbg_rr_last = rr_last;

  always_ff @(posedge clk1) begin
    if (reset) begin
      rr_last      <= SRC_ADD;
      cdb_valid    <= 1'b0;
      cdb_src      <= 1'b0;
      cdb_rob_ind  <= '0;
      cdb_rd       <= '0;
      cdb_rs_index <= '0;
      cdb_data     <= '0;
    end else begin
      cdb_valid <= grant_add || grant_mul;
      if (grant_add || grant_mul) begin
        rr_last      <= win.src;
        cdb_src      <= win.src;
        cdb_rob_ind  <= win.rob_ind;
        cdb_rd       <= win.rd;
        cdb_rs_index <= win.rs_index;
        cdb_data     <= win.data;
      end
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arb.sv
// Bench for cdb_writeback_arb: cycle-by-cycle vector table plus saturation and back-pressure streams.
module tb_cdb_writeback_arb;
  import tomasulo_pkg::*;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        add_valid = 1'b0, mul_valid = 1'b0;
  logic        add_ready, mul_ready;
  logic [2:0]  add_rob_ind = '0, mul_rob_ind = '0;
  logic [3:0]  add_rd = '0, mul_rd = '0;
  logic [2:0]  add_rs_index = '0, mul_rs_index = '0;
  logic [15:0] add_data = '0, mul_data = '0;
  logic        cdb_valid, cdb_src;
  logic [2:0]  cdb_rob_ind, cdb_rs_index;
  logic [3:0]  cdb_rd;
  logic [15:0] cdb_data;
  logic        dbg_rr_last;
  logic [1:0]  dbg_add_count, dbg_mul_count;

  cdb_writeback_arb dut (
    .clk1(clk1), .reset(reset), .flush(flush),
    .add_valid(add_valid), .add_ready(add_ready), .add_rob_ind(add_rob_ind),
    .add_rd(add_rd), .add_rs_index(add_rs_index), .add_data(add_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rob_ind(mul_rob_ind),
    .mul_rd(mul_rd), .mul_rs_index(mul_rs_index), .mul_data(mul_data),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_ind(cdb_rob_ind),
    .cdb_rd(cdb_rd), .cdb_rs_index(cdb_rs_index), .cdb_data(cdb_data),
    .dbg_rr_last(dbg_rr_last), .dbg_add_count(dbg_add_count), .dbg_mul_count(dbg_mul_count)
  );

  // clock / reset
  always #5 clk1 = ~clk1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int bcast;
  logic [25:0] exp_add_q[$];
  logic [25:0] exp_mul_q[$];

  typedef struct {
    logic        rst, fl;
    logic        av;
    logic [2:0]  arob;
    logic [15:0] adat;
    logic        mv;
    logic [2:0]  mrob;
    logic [3:0]  mrd;
    logic [2:0]  mrs;
    logic [15:0] mdat;
    logic        e_ar, e_mr, e_v, e_src;
    logic [2:0]  e_rob;
    logic [3:0]  e_rd;
    logic [2:0]  e_rs;
    logic [15:0] e_dat;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  function automatic vec_t v(input logic rst, input logic fl,
                             input logic av, input logic [2:0] arob, input logic [15:0] adat,
                             input logic mv, input logic [2:0] mrob, input logic [3:0] mrd,
                             input logic [2:0] mrs, input logic [15:0] mdat,
                             input logic e_ar, input logic e_mr, input logic e_v, input logic e_src,
                             input logic [2:0] e_rob, input logic [3:0] e_rd, input logic [2:0] e_rs,
                             input logic [15:0] e_dat);
    vec_t r;
    r.rst = rst; r.fl = fl; r.av = av; r.arob = arob; r.adat = adat;
    r.mv = mv; r.mrob = mrob; r.mrd = mrd; r.mrs = mrs; r.mdat = mdat;
    r.e_ar = e_ar; r.e_mr = e_mr; r.e_v = e_v; r.e_src = e_src;
    r.e_rob = e_rob; r.e_rd = e_rd; r.e_rs = e_rs; r.e_dat = e_dat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic drive_idle();
    add_valid = 1'b0; mul_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge clk1); @(posedge clk1); #1;
    reset = 1'b0;
    chk("rst_state", 32'({cdb_valid, dbg_rr_last, dbg_add_count, dbg_mul_count}), 32'h0);
  endtask

  task automatic check_cdb(input string tag);
    logic [25:0] got;
    got = {cdb_rob_ind, cdb_rd, cdb_rs_index, cdb_data};
    if (cdb_valid) begin
      bcast++;
      if (cdb_src) begin
        if (exp_mul_q.size() == 0) begin
          total_cnt++;
          $display("FAIL %s_mul_extra: got 0x%0h, expected no mul broadcast", tag, got);
        end else chk({tag, "_mul_order"}, 32'(got), 32'(exp_mul_q.pop_front()));
      end else begin
        if (exp_add_q.size() == 0) begin
          total_cnt++;
          $display("FAIL %s_add_extra: got 0x%0h, expected no add broadcast", tag, got);
        end else chk({tag, "_add_order"}, 32'(got), 32'(exp_add_q.pop_front()));
      end
    end
  endtask

  // Producers hold valid/payload until accepted; readiness checked for the first 8 cycles.
  task automatic run_stream(input string tag, input int n_add, input int n_mul, input int mul_delay,
                            input logic [7:0] exp_ar, input logic [7:0] exp_mr, input bit chk_alt);
    int  ai, mi;
    bit  acc_a, acc_m;
    ai = 0; mi = 0; bcast = 0;
    exp_add_q.delete(); exp_mul_q.delete();
    for (int c = 0; c < 24; c++) begin
      add_valid    = (ai < n_add);
      add_rob_ind  = 3'(ai);
      add_rd       = 4'hA;
      add_rs_index = 3'd2;
      add_data     = 16'h1000 + 16'(ai);
      mul_valid    = (c >= mul_delay) && (mi < n_mul);
      mul_rob_ind  = 3'(mi);
      mul_rd       = 4'(mi);
      mul_rs_index = 3'(mi + 1);
      mul_data     = 16'h2000 + 16'(mi);
      @(negedge clk1);
      if (c < 8)
        chk($sformatf("%s_ready_c%0d", tag, c), 32'({add_ready, mul_ready}), 32'({exp_ar[c], exp_mr[c]}));
      acc_a = add_valid && add_ready;
      acc_m = mul_valid && mul_ready;
      @(posedge clk1);
      if (acc_a) begin exp_add_q.push_back({add_rob_ind, add_rd, add_rs_index, add_data}); ai++; end
      if (acc_m) begin exp_mul_q.push_back({mul_rob_ind, mul_rd, mul_rs_index, mul_data}); mi++; end
      #1;
      check_cdb(tag);
      if (chk_alt && c >= 1 && c < 8)
        chk($sformatf("%s_alt_c%0d", tag, c), 32'({cdb_valid, cdb_src}), 32'({1'b1, c[0]}));
    end
    drive_idle();
    chk({tag, "_bcast_count"}, 32'(bcast), 32'(n_add + n_mul));
    chk({tag, "_left_over"}, 32'(exp_add_q.size() + exp_mul_q.size()), 32'h0);
  endtask

  initial begin
    //              rst fl av ar  adat      mv mr md ms mdat      ear emr v s rob rd    rs dat
    tbl[0]  = v(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0, 16'h0000);
    tbl[1]  = v(0, 0, 0, 0, 16'h0000, 1, 3, 5, 1, 16'h00C8, 1, 1, 0, 0, 0, 4'h0, 0, 16'h0000);
    tbl[2]  = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 3, 4'h5, 1, 16'h00C8);
    tbl[3]  = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 3, 4'h5, 1, 16'h00C8);
    tbl[4]  = v(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0, 16'h0000);
    tbl[5]  = v(0, 0, 1, 1, 16'h0007, 1, 2, 6, 4, 16'h0190, 1, 1, 0, 0, 0, 4'h0, 0, 16'h0000);
    tbl[6]  = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 2, 4'h6, 4, 16'h0190);
    tbl[7]  = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 1, 4'hA, 2, 16'h0007);
    tbl[8]  = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 1, 4'hA, 2, 16'h0007);
    tbl[9]  = v(0, 0, 1, 4, 16'h0011, 1, 5, 7, 3, 16'h0022, 1, 1, 0, 0, 1, 4'hA, 2, 16'h0007);
    tbl[10] = v(0, 0, 1, 6, 16'h0033, 1, 7, 1, 5, 16'h0044, 1, 1, 1, 1, 5, 4'h7, 3, 16'h0022);
    tbl[11] = v(0, 1, 1, 0, 16'h0055, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 5, 4'h7, 3, 16'h0022);
    tbl[12] = v(0, 0, 1, 3, 16'h0066, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 5, 4'h7, 3, 16'h0022);
    tbl[13] = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 3, 4'hA, 2, 16'h0066);
    tbl[14] = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 3, 4'hA, 2, 16'h0066);
    tbl[15] = v(0, 0, 1, 1, 16'h0101, 1, 2, 3, 6, 16'h0202, 1, 1, 0, 0, 3, 4'hA, 2, 16'h0066);
    tbl[16] = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 2, 4'h3, 6, 16'h0202);
    tbl[17] = v(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0, 16'h0000);
    tbl[18] = v(0, 0, 1, 5, 16'h0505, 1, 6, 9, 7, 16'h0606, 1, 1, 0, 0, 0, 4'h0, 0, 16'h0000);
    tbl[19] = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 6, 4'h9, 7, 16'h0606);
    tbl[20] = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 5, 4'hA, 2, 16'h0505);
    tbl[21] = v(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 5, 4'hA, 2, 16'h0505);

    for (int i = 0; i < NV; i++) begin
      reset        = tbl[i].rst;
      flush        = tbl[i].fl;
      add_valid    = tbl[i].av;
      add_rob_ind  = tbl[i].arob;
      add_rd       = 4'hA;
      add_rs_index = 3'd2;
      add_data     = tbl[i].adat;
      mul_valid    = tbl[i].mv;
      mul_rob_ind  = tbl[i].mrob;
      mul_rd       = tbl[i].mrd;
      mul_rs_index = tbl[i].mrs;
      mul_data     = tbl[i].mdat;
      @(negedge clk1);
      chk($sformatf("v%0d_ready", i), 32'({add_ready, mul_ready}), 32'({tbl[i].e_ar, tbl[i].e_mr}));
      @(posedge clk1); #1;
      chk($sformatf("v%0d_cdb", i),
          32'({cdb_valid, cdb_src, cdb_rob_ind, cdb_rd, cdb_rs_index, cdb_data}),
          32'({tbl[i].e_v, tbl[i].e_src, tbl[i].e_rob, tbl[i].e_rd, tbl[i].e_rs, tbl[i].e_dat}));
    end

    // saturation: alternating grants, ready drops once a buffer holds two
    do_reset();
    run_stream("sat", 5, 6, 0, 8'b10101011, 8'b01010111, 1'b1);

    // back-pressure: 4th mul result stalls while mul buffer is full
    do_reset();
    run_stream("bp", 5, 4, 1, 8'b01010111, 8'b10101111, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
